p_reg_ctrl: RTL and testbench
=============================

// Module: p_reg_ctrl
// PURPOSE
//  Owns the 65C816 processor status register P (N V M X D I Z C, bits 7..0) and the E flag.
//  Sequences every flag-changing source:
//  - ALU flag update
//  - REP/SEP
//  - PLP
//  - XCE
//  - interrupt entry
//  Applies one source per cpu_en cycle; a colliding loser is buffered in a one-deep pending slot.
//  Enforces emulation-mode rules and signals index high-byte clears to the register file.
// PARAMETERS
//  P_RESET   8'h34  P value loaded on reset (M, X, I set)
//  E_RESET   1'b1   E value loaded on reset
// PORTS
//  clk          in   1  clock
//  reset        in   1  synchronous, active-high reset
//  cpu_en       in   1  CPU clock enable; all state advances only when 1
//  alu_we       in   1  ALU flag update request
//  alu_mask     in   8  bits of P the ALU writes
//  alu_flags    in   8  new flag values (used under alu_mask)
//  rep_we       in   1  REP/SEP request
//  rep_set      in   1  1 = SEP (set masked bits), 0 = REP (clear masked bits)
//  rep_mask     in   8  immediate operand of REP/SEP
//  plp_we       in   1  PLP request; full P load
//  plp_data     in   8  byte pulled from the stack
//  xce_req      in   1  exchange C and E
//  int_req      in   1  interrupt entry: set I, clear D
//  int_brk      in   1  entry is BRK (affects p_push bit 4 in emulation)
//  p_out        out  8  current P (reset P_RESET)
//  e_out        out  1  current E (reset E_RESET)
//  p_push       out  8  P image to push on interrupt entry (reset 8'h00)
//  idx_hi_clr   out  1  one-cycle pulse: clear X/Y high bytes (reset 0)
//  busy         out  1  pending slot occupied; sequencer must not issue new requests (reset 0)
//  drop_err     out  1  sticky: a request was discarded (reset 0; cleared only by reset)
// BEHAVIOUR
//  - Requests are sampled only when cpu_en = 1. Outputs change only on cpu_en clock edges.
//  - Latency: an accepted update is visible on p_out/e_out the cycle after the accepting edge.
//  - Priority (high to low): INT > PLP > XCE > REP/SEP > ALU.
//    The pending entry competes at its original priority.
//  - Winner is applied each cpu_en cycle.
//    Exactly one loser (the highest-priority loser) is stored in pending.
//    Any further losers are dropped and set drop_err.
//  - If pending is full and a new lower-priority request loses, it is dropped and sets drop_err.
//  - If a new request outranks pending, pending is applied after it.
//  - Apply rules:
//    - ALU: P = (P & ~mask) | (flags & mask).
//    - SEP: P |= mask.
//    - REP: P &= ~mask.
//    - PLP: P = data.
//    - XCE: {C, E} = {E, C}.
//    - INT: I = 1, D = 0.
//      p_push = P before the update; in emulation, bit 4 = int_brk and bit 5 = 1.
//  - Emulation (E = 1 after the update): M and X are forced to 1 regardless of source.
//  - idx_hi_clr pulses for exactly one cpu_en cycle whenever X goes 0 -> 1.
//    This includes XCE entering emulation. The pulse coincides with the new p_out.
//  - busy = pending valid. It is set and cleared on cpu_en edges only.
//  - Reset mid-operation discards pending and any idx_hi_clr pulse.
//    All outputs return to their reset values in the next cycle.
//  - cpu_en = 0: all state, including pending and pulses, holds unchanged.
// STRUCTURE
//  cpu_pkg (shared package):
//  - flag bit index localparams FLG_C .. FLG_N.
//  - enum p_src_t {SRC_NONE, SRC_ALU, SRC_REP, SRC_XCE, SRC_PLP, SRC_INT}.
//  - struct p_req_t {src, mask, data, set, brk}.
//  Sub-module p_req_arb:
//  - priority select across new requests plus the pending slot.
//  - pending register, busy, drop_err.
//  - outputs the winning p_req_t.
//  Top level: apply/force logic, P/E storage, p_push, idx_hi_clr edge detect.
// TESTING
//  1. Reset.
//     -> p_out = 8'h34, e_out = 1.
//     SEP #$00 with E = 1 -> p_out stays 8'h34.
//     REP #$30 with E = 1 -> M/X remain 1.
//  2. XCE with C = 0, E = 1.
//     -> e_out = 0, C = 1.
//     Then REP #$10 -> X = 0.
//     Then SEP #$10 -> X = 1 and idx_hi_clr high for one cycle.
//  3. Same cycle: alu_we (mask 8'h82, flags 8'h80) + rep_we (REP #$01).
//     -> REP is applied first and busy = 1.
//     The next cpu_en cycle applies ALU: N = 1, Z = 0, busy = 0.
//  4. Same cycle: INT + PLP + ALU.
//     -> INT is applied, PLP goes to pending, ALU is dropped and drop_err = 1.
//     The next cycle gives p_out = plp_data (M/X forced if E).
//  5. int_req, int_brk = 1, E = 1, P = 8'h3C.
//     -> p_push = 8'h3C | 8'h30, p_out = 8'h34.
//  6. Hold cpu_en = 0 for 5 cycles with requests asserted -> no change.
//     Assert reset while busy = 1 -> busy = 0 and p_out = 8'h34 the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 65C816 status-register slice.
//  - FLG_* : bit positions of the flags inside P (N V M X D I Z C = 7..0)
//  - p_src_t : flag-changing source; the encoding order is also the priority order
//  - p_req_t : one flag-update request as it travels through the arbiter
//  - lvl_src : maps an arbitration level (0 = highest) to its source
package cpu_pkg;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_I = 2;
  localparam int FLG_D = 3;
  localparam int FLG_X = 4;
  localparam int FLG_M = 5;
  localparam int FLG_V = 6;
  localparam int FLG_N = 7;

  // Number of real (non-NONE) sources, one arbitration level each.
  localparam int NUM_LVL = 5;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_ALU  = 3'd1,
    SRC_REP  = 3'd2,
    SRC_XCE  = 3'd3,
    SRC_PLP  = 3'd4,
    SRC_INT  = 3'd5
  } p_src_t;

  typedef struct packed {
    p_src_t     src;   // SRC_NONE marks an empty request / slot
    logic [7:0] mask;  // ALU write mask or REP/SEP operand
    logic [7:0] data;  // ALU flag values or PLP byte
    logic       set;   // REP/SEP: 1 = SEP
    logic       brk;   // INT: entry caused by BRK
  } p_req_t;

  localparam p_req_t REQ_NONE = '{src: SRC_NONE, mask: 8'h00, data: 8'h00,
                                  set: 1'b0, brk: 1'b0};

  // Level 0 is the highest priority.
  function automatic p_src_t lvl_src(input int lvl);
    case (lvl)
      0:       return SRC_INT;
      1:       return SRC_PLP;
      2:       return SRC_XCE;
      3:       return SRC_REP;
      default: return SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/p_reg_ctrl_arb.sv
// p_reg_ctrl_arb (module p_req_arb): priority select across the new requests
// and the one-deep pending slot.
//  clk, reset  : clock, synchronous active-high reset
//  cpu_en      : clock enable; pending and drop_err change only when 1
//  new_req     : one request per level, index 0 = highest priority;
//                src = SRC_NONE when that source is idle
//  win_req     : winning request this cycle (SRC_NONE if nothing to do)
//  busy        : pending slot occupied
//  drop_err    : sticky, a request was discarded
module p_req_arb
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_en,
  input  p_req_t [NUM_LVL-1:0]   new_req,
  output p_req_t                 win_req,
  output logic                   busy,
  output logic                   drop_err
);

  p_req_t pend_reg;
  logic   drop_err_reg;

  // Candidates in strict service order. At each level the pending entry is
  // placed ahead of a new request of the same source, so the older one goes first.
  p_req_t slot [2*NUM_LVL];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LVL; gi++) begin : g_slot
      assign slot[2*gi]   = (pend_reg.src == lvl_src(gi)) ? pend_reg : REQ_NONE;
      assign slot[2*gi+1] = new_req[gi];
    end
  endgenerate

  p_req_t     win_next;
  p_req_t     pend_next;
  logic       drop_next;
  logic [1:0] taken;

  // First valid candidate wins, second becomes pending, the rest are dropped.
  always_comb begin
    win_next  = REQ_NONE;
    pend_next = REQ_NONE;
    drop_next = 1'b0;
    taken     = 2'd0;
    for (int i = 0; i < 2*NUM_LVL; i++) begin
      if (slot[i].src != SRC_NONE) begin
        if (taken == 2'd0) begin
          win_next = slot[i];
        end else if (taken == 2'd1) begin
          pend_next = slot[i];
        end else begin
          drop_next = 1'b1;
        end
        if (taken != 2'd2) begin
          taken = taken + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg     <= REQ_NONE;
      drop_err_reg <= 1'b0;
    end else if (cpu_en) begin
      pend_reg <= pend_next;
      if (drop_next) begin
        drop_err_reg <= 1'b1;
      end
    end
  end

  assign win_req  = win_next;
  assign busy     = (pend_reg.src != SRC_NONE);
  assign drop_err = drop_err_reg;

endmodule

// File: rtl/p_reg_ctrl.sv
// p_reg_ctrl: owns the 65C816 status register P and the E flag.
//  clk, reset        : clock, synchronous active-high reset
//  cpu_en            : CPU clock enable; all state advances only when 1
//  alu_we/mask/flags : ALU flag update, P = (P & ~mask) | (flags & mask)
//  rep_we/set/mask   : REP (set=0) / SEP (set=1) with immediate mask
//  plp_we/plp_data   : full P load from the stack
//  xce_req           : swap C and E
//  int_req/int_brk   : interrupt entry (I=1, D=0), BRK marker for p_push
//  p_out, e_out      : current P and E
//  p_push            : P image captured at interrupt entry
//  idx_hi_clr        : one-cycle pulse when X rises 0 -> 1
//  busy, drop_err    : arbiter pending-slot status / sticky discard flag
module p_reg_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] P_RESET = 8'h34,
  parameter logic       E_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       alu_we,
  input  logic [7:0] alu_mask,
  input  logic [7:0] alu_flags,
  input  logic       rep_we,
  input  logic       rep_set,
  input  logic [7:0] rep_mask,
  input  logic       plp_we,
  input  logic [7:0] plp_data,
  input  logic       xce_req,
  input  logic       int_req,
  input  logic       int_brk,
  output logic [7:0] p_out,
  output logic       e_out,
  output logic [7:0] p_push,
  output logic       idx_hi_clr,
  output logic       busy,
  output logic       drop_err
);

  p_req_t [NUM_LVL-1:0] new_req;
  p_req_t               win_req;

  // Index order follows lvl_src(): INT, PLP, XCE, REP, ALU.
  assign new_req[0] = int_req ? '{SRC_INT, 8'h00, 8'h00, 1'b0, int_brk}     : REQ_NONE;
  assign new_req[1] = plp_we  ? '{SRC_PLP, 8'hFF, plp_data, 1'b0, 1'b0}    : REQ_NONE;
  assign new_req[2] = xce_req ? '{SRC_XCE, 8'h00, 8'h00, 1'b0, 1'b0}       : REQ_NONE;
  assign new_req[3] = rep_we  ? '{SRC_REP, rep_mask, 8'h00, rep_set, 1'b0} : REQ_NONE;
  assign new_req[4] = alu_we  ? '{SRC_ALU, alu_mask, alu_flags, 1'b0, 1'b0} : REQ_NONE;

  p_req_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .cpu_en   (cpu_en),
    .new_req  (new_req),
    .win_req  (win_req),
    .busy     (busy),
    .drop_err (drop_err)
  );

  logic [7:0] p_reg, p_next;
  logic       e_reg, e_next;
  logic [7:0] p_push_reg, p_push_next;
  logic       idx_hi_clr_reg, idx_hi_clr_next;

  always_comb begin
    p_next      = p_reg;
    e_next      = e_reg;
    p_push_next = p_push_reg;
    case (win_req.src)
      SRC_ALU: p_next = (p_reg & ~win_req.mask) | (win_req.data & win_req.mask);
      SRC_REP: p_next = win_req.set ? (p_reg | win_req.mask) : (p_reg & ~win_req.mask);
      SRC_PLP: p_next = win_req.data;
      SRC_XCE: begin
        p_next[FLG_C] = e_reg;
        e_next        = p_reg[FLG_C];
      end
      SRC_INT: begin
        p_next[FLG_I] = 1'b1;
        p_next[FLG_D] = 1'b0;
        // Pushed image is P before entry; in emulation bits 5/4 become 1/B.
        p_push_next   = p_reg;
        if (e_reg) begin
          p_push_next[5] = 1'b1;
          p_push_next[4] = win_req.brk;
        end
      end
      default: ;
    endcase
    // Emulation pins M and X high whatever the source wrote.
    if (e_next) begin
      p_next[FLG_M] = 1'b1;
      p_next[FLG_X] = 1'b1;
    end
    // Narrowing the index registers must also clear their high bytes.
    idx_hi_clr_next = ~p_reg[FLG_X] & p_next[FLG_X];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_reg          <= P_RESET;
      e_reg          <= E_RESET;
      p_push_reg     <= 8'h00;
      idx_hi_clr_reg <= 1'b0;
    end else if (cpu_en) begin
      p_reg          <= p_next;
      e_reg          <= e_next;
      p_push_reg     <= p_push_next;
      idx_hi_clr_reg <= idx_hi_clr_next;
    end
  end

  assign p_out      = p_reg;
  assign e_out      = e_reg;
  assign p_push     = p_push_reg;
  assign idx_hi_clr = idx_hi_clr_reg;

endmodule

// File: tb/tb_p_reg_ctrl.sv
module tb_p_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset, cpu_en;
  logic       alu_we, rep_we, rep_set, plp_we, xce_req, int_req, int_brk;
  logic [7:0] alu_mask, alu_flags, rep_mask, plp_data;
  logic [7:0] p_out, p_push;
  logic       e_out, idx_hi_clr, busy, drop_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  p_reg_ctrl dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en),
    .alu_we(alu_we), .alu_mask(alu_mask), .alu_flags(alu_flags),
    .rep_we(rep_we), .rep_set(rep_set), .rep_mask(rep_mask),
    .plp_we(plp_we), .plp_data(plp_data), .xce_req(xce_req),
    .int_req(int_req), .int_brk(int_brk),
    .p_out(p_out), .e_out(e_out), .p_push(p_push),
    .idx_hi_clr(idx_hi_clr), .busy(busy), .drop_err(drop_err)
  );

  // ---------------- behavioural model ----------------
  // pri: 5 INT, 4 PLP, 3 XCE, 2 REP, 1 ALU. 'old' marks the pending entry,
  // which is served before a new request of equal priority.
  typedef struct {
    int       pri;
    bit [7:0] mask;
    bit [7:0] data;
    bit       set;
    bit       brk;
    bit       old;
  } mreq_t;

  typedef struct {
    bit [7:0] p;
    bit       e;
    bit [7:0] push;
    bit       clr;
    bit       pv;
    mreq_t    pr;
    bit       drop;
  } mstate_t;

  mstate_t m;

  function automatic int best_idx(input mreq_t q[$]);
    int b = 0;
    for (int i = 1; i < q.size(); i++)
      if (q[i].pri * 2 + int'(q[i].old) > q[b].pri * 2 + int'(q[b].old)) b = i;
    return b;
  endfunction

  function automatic mstate_t model_step(input mstate_t s);
    mstate_t n;
    mreq_t   q[$];
    mreq_t   w, r;
    int      k;
    if (reset) begin
      n.p = 8'h34; n.e = 1'b1; n.push = 8'h00; n.clr = 1'b0;
      n.pv = 1'b0; n.drop = 1'b0;
      n.pr = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      return n;
    end
    if (!cpu_en) return s;
    n = s;
    n.clr = 1'b0;
    n.pv = 1'b0;
    if (s.pv) begin r = s.pr; r.old = 1'b1; q.push_back(r); end
    if (int_req) q.push_back('{5, 8'h00, 8'h00, 1'b0, int_brk, 1'b0});
    if (plp_we)  q.push_back('{4, 8'h00, plp_data, 1'b0, 1'b0, 1'b0});
    if (xce_req) q.push_back('{3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
    if (rep_we)  q.push_back('{2, rep_mask, 8'h00, rep_set, 1'b0, 1'b0});
    if (alu_we)  q.push_back('{1, alu_mask, alu_flags, 1'b0, 1'b0, 1'b0});
    if (q.size() == 0) return n;
    k = best_idx(q); w = q[k]; q.delete(k);
    if (q.size() > 0) begin
      k = best_idx(q); n.pr = q[k]; n.pv = 1'b1; q.delete(k);
      if (q.size() > 0) n.drop = 1'b1;
    end
    case (w.pri)
      1: n.p = (s.p & ~w.mask) | (w.data & w.mask);
      2: n.p = w.set ? (s.p | w.mask) : (s.p & ~w.mask);
      3: begin n.e = s.p[0]; n.p[0] = s.e; end
      4: n.p = w.data;
      default: begin
        n.push = s.e ? {s.p[7:6], 1'b1, w.brk, s.p[3:0]} : s.p;
        n.p = (s.p | 8'h04) & 8'hF7;
      end
    endcase
    if (n.e) n.p = n.p | 8'h30;
    n.clr = !s.p[4] && n.p[4];
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model p_out", p_out, m.p);
    chk("model e_out", {7'd0, e_out}, {7'd0, m.e});
    chk("model p_push", p_push, m.push);
    chk("model idx_hi_clr", {7'd0, idx_hi_clr}, {7'd0, m.clr});
    chk("model busy", {7'd0, busy}, {7'd0, m.pv});
    chk("model drop_err", {7'd0, drop_err}, {7'd0, m.drop});
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    alu_we = 0; rep_we = 0; plp_we = 0; xce_req = 0; int_req = 0; int_brk = 0;
    rep_set = 0; alu_mask = 0; alu_flags = 0; rep_mask = 0; plp_data = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rep(input bit s, input logic [7:0] mk);
    idle(); rep_we = 1; rep_set = s; rep_mask = mk;
  endtask

  initial begin
    reset = 1; cpu_en = 1; idle();
    cyc(); cyc();
    // 1. reset and emulation forcing
    chk("reset p_out", p_out, 8'h34);
    chk("reset e_out", {7'd0, e_out}, 8'h01);
    chk("reset p_push", p_push, 8'h00);
    reset = 0; rep(1, 8'h00); cyc();
    chk("sep00 emu", p_out, 8'h34);
    rep(0, 8'h30); cyc();
    chk("rep30 emu", p_out, 8'h34);
    // 2. XCE to native, then X clear / set
    idle(); xce_req = 1; cyc();
    chk("xce e_out", {7'd0, e_out}, 8'h00);
    chk("xce p_out", p_out, 8'h35);
    rep(0, 8'h10); cyc();
    chk("rep10 native", p_out, 8'h25);
    rep(1, 8'h10); cyc();
    chk("sep10 native", p_out, 8'h35);
    chk("sep10 idx_hi_clr", {7'd0, idx_hi_clr}, 8'h01);
    idle(); cyc();
    chk("idx_hi_clr one cycle", {7'd0, idx_hi_clr}, 8'h00);
    // 3. ALU + REP collision
    rep(0, 8'h01); alu_we = 1; alu_mask = 8'h82; alu_flags = 8'h80; cyc();
    chk("collide rep first", p_out, 8'h34);
    chk("collide busy", {7'd0, busy}, 8'h01);
    idle(); cyc();
    chk("pending alu", p_out, 8'hB4);
    chk("pending drained", {7'd0, busy}, 8'h00);
    // 4. INT + PLP + ALU
    idle(); int_req = 1; plp_we = 1; plp_data = 8'h0F; alu_we = 1; alu_mask = 8'hFF;
    cyc();
    chk("int wins", p_out, 8'hB4);
    chk("int push native", p_push, 8'hB4);
    chk("plp pending", {7'd0, busy}, 8'h01);
    chk("alu dropped", {7'd0, drop_err}, 8'h01);
    idle(); cyc();
    chk("plp applied", p_out, 8'h0F);
    // 5. BRK in emulation with P = 3C
    idle(); plp_we = 1; plp_data = 8'h3D; cyc();
    idle(); xce_req = 1; cyc();
    chk("emu p 3C", p_out, 8'h3C);
    idle(); int_req = 1; int_brk = 1; cyc();
    chk("brk push", p_push, 8'h3C);
    chk("brk p_out", p_out, 8'h34);
    // 6. cpu_en hold, then reset while busy
    idle(); cpu_en = 0; alu_we = 1; alu_mask = 8'hFF; rep_we = 1; rep_mask = 8'hFF; plp_we = 1;
    repeat (5) cyc();
    chk("hold p_out", p_out, 8'h34);
    chk("hold busy", {7'd0, busy}, 8'h00);
    cpu_en = 1; rep(0, 8'h00); alu_we = 1; cyc();
    chk("busy before hold", {7'd0, busy}, 8'h01);
    cpu_en = 0; xce_req = 1; int_req = 1;
    repeat (5) cyc();
    chk("hold keeps pending", {7'd0, busy}, 8'h01);
    chk("hold keeps e", {7'd0, e_out}, 8'h01);
    cpu_en = 1; idle(); reset = 1; cyc();
    chk("reset clears busy", {7'd0, busy}, 8'h00);
    chk("reset p_out mid-op", p_out, 8'h34);
    chk("reset drop_err", {7'd0, drop_err}, 8'h00);
    reset = 0;
    // randomized phase, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      cpu_en    = ($urandom_range(0, 9) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      int_req   = ($urandom_range(0, 5) == 0);
      int_brk   = $urandom_range(0, 1);
      plp_we    = ($urandom_range(0, 3) == 0);
      plp_data  = 8'($urandom);
      xce_req   = ($urandom_range(0, 3) == 0);
      rep_we    = ($urandom_range(0, 2) == 0);
      rep_set   = $urandom_range(0, 1);
      rep_mask  = 8'($urandom);
      alu_we    = ($urandom_range(0, 1) == 0);
      alu_mask  = 8'($urandom);
      alu_flags = 8'($urandom);
      cyc();
    end
    idle(); reset = 0; cpu_en = 1;
    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
